instr_store_loader: RTL

Byte-serial program loader that fills the core's instruction store before execution. It accepts an eBPF program as a little-endian byte stream over a valid/ready handshake and packs each 8 bytes into one 64-bit instruction slot. It writes each slot to the instruction store write port at consecutive word addresses, recognises `lddw` double-slot instructions and the `exit` opcode, and holds the core until a complete, well-formed program has been loaded.

---
 rtl/instr_store_loader_if.sv | 20 ++
 rtl/instr_store_loader.sv | 116 +++++++++++
 2 files changed

// File: rtl/instr_store_loader_if.sv
// Byte-stream intake and instruction store write port of the program loader.
// The loader uses the slave view; the byte source and store use the master view.
interface instr_store_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_store_loader.sv
// Packs a little-endian byte stream into 64-bit eBPF slots, writes them to the
// instruction store and releases the core once an exit-terminated program is in.
module instr_store_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_store_loader_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           prog_len,
  output logic                  cpu_hold
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0]            cnt;
  logic                  hi;
  logic [63:0]           shift;
  logic [31:0]           len_q;
  logic                  accept;
  logic [7:0]            opcode;
  logic                  last_slot;

  assign accept    = (state == RECV) && bus.byte_valid;
  assign opcode    = shift[7:0];
  assign last_slot = (addr == {ADDR_WIDTH{1'b1}});

  // Next-state decode; a malformed lddw high half wins over exit and overflow.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = RECV;
      RECV:  if (accept && cnt == 3'd7) state_nx = WRITE;
      WRITE: begin
        if (hi && opcode != 8'h00)
          state_nx = ERR;
        else if (!hi && opcode == 8'h95)
          state_nx = DONE;
        else if (last_slot)
          state_nx = ERR;
        else
          state_nx = RECV;
      end
      DONE:  if (start) state_nx = RECV;
      ERR:   if (start) state_nx = RECV;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      hi    <= 1'b0;
      shift <= '0;
      len_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          addr  <= '0;
          cnt   <= '0;
          hi    <= 1'b0;
          len_q <= '0;
        end
        RECV: begin
          if (accept) begin
            shift[{cnt, 3'b000} +: 8] <= bus.byte_data;
            cnt                       <= cnt + 3'd1;
          end
        end
        WRITE: begin
          hi  <= !hi && (opcode == 8'h18);
          cnt <= '0;
          if (state_nx == DONE)
            len_q <= 32'(addr) + 32'd1;
          if (state_nx == RECV)
            addr <= addr + 1'b1;
        end
        DONE, ERR: begin
          // A restart begins a fresh load at slot zero without passing through IDLE.
          if (start) begin
            addr  <= '0;
            cnt   <= '0;
            hi    <= 1'b0;
            len_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = (state == RECV);
  assign bus.wr_en      = (state == WRITE);
  assign bus.wr_addr    = 32'(addr);
  assign bus.wr_data    = shift;
  assign busy           = (state == RECV) || (state == WRITE);
  assign done           = (state == DONE);
  assign error          = (state == ERR);
  assign cpu_hold       = (state != DONE);
  assign prog_len       = len_q;

endmodule
